// File: rtl/pong_score_ctrl.sv
// Score keeper for the ping-pong game: arbitrates left/right point pulses onto a
// single shared 2-digit BCD incrementer, detects the winning score and rotates serve.
module pong_score_ctrl #(
  parameter logic [7:0]  WIN_SCORE    = 8'h11,
  parameter int unsigned SERVE_EVERY  = 2,
  parameter logic        FIRST_SERVER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       point_L,
  input  logic       point_R,
  input  logic       new_game,
  output logic [7:0] score_L,
  output logic [7:0] score_R,
  output logic       server,
  output logic       score_upd,
  output logic       game_over,
  output logic       winner,
  output logic       busy,
  output logic       lost_pt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INC_L = 3'd1,
    INC_R = 3'd2,
    CHECK = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int unsigned CNT_W = (SERVE_EVERY < 2) ? 1 : $clog2(SERVE_EVERY);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_EVERY - 1);

  state_t           state, next_state;
  logic             pend_l, pend_r;
  logic             rr;
  logic             side, side_nxt;
  logic [CNT_W-1:0] serve_cnt;

  logic             rr_flip;
  logic             do_inc;
  logic             clr_pend_l, clr_pend_r;
  logic             win;
  logic             serve_adv;
  logic             set_l, set_r;
  logic [7:0]       inc_src, inc_res;
  logic             win_hit;

  // Two-digit BCD increment; each nibble wraps 9 -> 0, and 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo, hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // The one incrementer is shared; `side` selects which score register feeds it.
  assign inc_src = side ? score_R : score_L;
  assign inc_res = bcd_inc(inc_src);
  assign win_hit = (inc_src == WIN_SCORE);

  assign set_l = point_L && !game_over;
  assign set_r = point_R && !game_over;

  // OVER is a resting state, so it does not count as busy.
  assign busy = pend_l || pend_r || (state inside {INC_L, INC_R, CHECK});

  // NOTE: asynchronous reset lives only in the sensitivity list; new_game is an
  // ordinary synchronous condition checked first inside the clocked branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (new_game) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    side_nxt   = side;
    rr_flip    = 1'b0;
    do_inc     = 1'b0;
    clr_pend_l = 1'b0;
    clr_pend_r = 1'b0;
    score_upd  = 1'b0;
    win        = 1'b0;
    serve_adv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_l && pend_r) begin
          side_nxt   = rr;
          next_state = rr ? INC_R : INC_L;
          rr_flip    = 1'b1;
        end else if (pend_l) begin
          side_nxt   = 1'b0;
          next_state = INC_L;
        end else if (pend_r) begin
          side_nxt   = 1'b1;
          next_state = INC_R;
        end
      end
      INC_L: begin
        do_inc     = 1'b1;
        clr_pend_l = 1'b1;
        next_state = CHECK;
      end
      INC_R: begin
        do_inc     = 1'b1;
        clr_pend_r = 1'b1;
        next_state = CHECK;
      end
      CHECK: begin
        score_upd = 1'b1;
        if (win_hit) begin
          win        = 1'b1;
          next_state = OVER;
        end else begin
          serve_adv  = 1'b1;
          next_state = IDLE;
        end
      end
      OVER: begin
        clr_pend_l = 1'b1;
        clr_pend_r = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_L   <= 8'h00;
      score_R   <= 8'h00;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      serve_cnt <= '0;
      server    <= FIRST_SERVER;
      game_over <= 1'b0;
      winner    <= 1'b0;
      lost_pt   <= 1'b0;
      rr        <= 1'b0;
      side      <= 1'b0;
    end else if (new_game) begin
      score_L   <= 8'h00;
      score_R   <= 8'h00;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      serve_cnt <= '0;
      server    <= FIRST_SERVER;
      game_over <= 1'b0;
      winner    <= 1'b0;
      lost_pt   <= 1'b0;
      rr        <= 1'b0;
      side      <= 1'b0;
    end else begin
      // A new point wins over a same-cycle clear, so it is never lost.
      pend_l <= set_l || (pend_l && !clr_pend_l);
      pend_r <= set_r || (pend_r && !clr_pend_r);
      if ((set_l && pend_l && !clr_pend_l) || (set_r && pend_r && !clr_pend_r)) begin
        lost_pt <= 1'b1;
      end

      side <= side_nxt;
      if (rr_flip) begin
        rr <= ~rr;
      end

      if (do_inc) begin
        if (side) begin
          score_R <= inc_res;
        end else begin
          score_L <= inc_res;
        end
      end

      if (win) begin
        game_over <= 1'b1;
        winner    <= side;
      end

      if (serve_adv) begin
        if (serve_cnt == SERVE_LAST) begin
          serve_cnt <= '0;
          server    <= ~server;
        end else begin
          serve_cnt <= serve_cnt + 1'b1;
        end
      end
    end
  end

endmodule
